// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter
// Purpose  : Iterative radix-2 shift-add multiplier (MULT/MULTU/MUL) that
//            stalls the pipeline while a product is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic                 Flush,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   MULout,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Stall
);

    localparam int              c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_FIX  = 2'd2,
        c_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_mulout;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && Start && !Flush;
    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign w_a_mag  = (Signed && A[WIDTH-1]) ? -A : A;
    assign w_b_mag  = (Signed && B[WIDTH-1]) ? -B : B;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE, c_DONE: w_next = w_accept ? c_RUN : c_IDLE;
            c_RUN: begin
                if (Flush) begin
                    w_next = c_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = c_FIX;
                end else begin
                    w_next = c_RUN;
                end
            end
            c_FIX:   w_next = Flush ? c_IDLE : c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    // Multiplicand shifts left one place per cycle instead of a barrel shift by r_cnt.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_mulout <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next == c_RUN) || (w_next == c_FIX);
            r_done <= (w_next == c_DONE);
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_cnt    <= '0;
                        r_neg    <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    end
                end
                c_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + c_CW'(1);
                end
                c_FIX: begin
                    if (!Flush) begin
                        r_mulout <= r_neg ? -r_acc : r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MULout = r_mulout;
    assign Busy   = r_busy;
    assign Done   = r_done;
    assign Stall  = (Start && ((r_state == c_IDLE) || (r_state == c_DONE)) && !Flush) || r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_iter
// Purpose  : Self-checking bench for mul_iter against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_iter;

    localparam int c_W   = 32;
    localparam int c_LAT = c_W + 2;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic              Signed = 1'b0;
    logic              Flush = 1'b0;
    logic [c_W-1:0]    A = '0;
    logic [c_W-1:0]    B = '0;
    logic [2*c_W-1:0]  MULout;
    logic              Busy;
    logic              Done;
    logic              Stall;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [2*c_W-1:0]  last_prod = '0;

    mul_iter #(.WIDTH(c_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Signed(Signed),
        .Flush (Flush),
        .A     (A),
        .B     (B),
        .MULout(MULout),
        .Busy  (Busy),
        .Done  (Done),
        .Stall (Stall)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Cycle 0 is the accept cycle; expectations come from the latency and abort rules.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit chain, input int disturb_at,
                          input int flush_at, input int rst_at, input string name);
        int          abort_c;
        int          last_c;
        logic        e_busy, e_done, e_stall;
        logic [63:0] e_out;
        abort_c = (flush_at != 0) ? flush_at : rst_at;
        last_c  = (abort_c != 0) ? c_LAT + 6 : c_LAT;
        if (!chain) @(negedge Clock);
        Start = 1'b1; A = a; B = b; Signed = s;
        #1;
        n_tests++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall_c0: got %b want 1", name, Stall);
        end
        for (int c = 1; c <= last_c; c++) begin
            @(negedge Clock);
            if (abort_c != 0 && c > abort_c) begin
                e_busy = 1'b0; e_done = 1'b0; e_stall = 1'b0;
                e_out  = (rst_at != 0) ? 64'h0 : last_prod;
            end else begin
                e_busy  = (c <= c_LAT - 1);
                e_done  = (c == c_LAT);
                e_stall = (c <= c_LAT - 1);
                e_out   = (c == c_LAT) ? exp : last_prod;
            end
            n_tests++;
            if (Busy !== e_busy) begin
                n_fail++;
                $display("FAIL %s busy c%0d: got %b want %b", name, c, Busy, e_busy);
            end
            n_tests++;
            if (Done !== e_done) begin
                n_fail++;
                $display("FAIL %s done c%0d: got %b want %b", name, c, Done, e_done);
            end
            n_tests++;
            if (Stall !== e_stall) begin
                n_fail++;
                $display("FAIL %s stall c%0d: got %b want %b", name, c, Stall, e_stall);
            end
            n_tests++;
            if (MULout !== e_out) begin
                n_fail++;
                $display("FAIL %s mulout c%0d: got %h want %h", name, c, MULout, e_out);
            end
            if (c == 1) Start = 1'b0;
            if (c == disturb_at) begin
                Start = 1'b1; A = $urandom; B = $urandom; Signed = ~Signed;
            end
            if (disturb_at != 0 && c == disturb_at + 1) Start = 1'b0;
            if (c == flush_at) Flush = 1'b1;
            if (flush_at != 0 && c == flush_at + 1) Flush = 1'b0;
            if (c == rst_at) Reset = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) Reset = 1'b0;
        end
        if (rst_at != 0) last_prod = '0;
        else if (flush_at == 0) last_prod = exp;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; Flush = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        n_tests++;
        if (MULout !== 64'h0 || Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got mul=%h busy=%b done=%b stall=%b want 0", MULout, Busy, Done, Stall);
        end
        Start = 1'b1;
        #1;
        n_tests++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_start: got %b want 1", Stall);
        end
        @(negedge Clock);
        n_tests++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_holds_idle: busy got %b want 0", Busy);
        end
        Start = 1'b0; Reset = 1'b0;
        last_prod = '0;
    endtask

    task automatic test_flush_idle;
        @(negedge Clock);
        Start = 1'b1; Flush = 1'b1; A = 32'd3; B = 32'd4;
        #1;
        n_tests++;
        if (Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_stall: got %b want 0", Stall);
        end
        @(negedge Clock);
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: busy=%b done=%b want 0 0", Busy, Done);
        end
        Start = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_vectors;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b0, 0, 0, 0, "umax");
        run_op(32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b0, 0, 0, 0, "neg3x7_s");
        run_op(32'hFFFFFFFD, 32'd7, 1'b0, 64'h00000006FFFFFFEB, 1'b0, 0, 0, 0, "neg3x7_u");
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b0, 0, 0, 0, "minxmin");
        run_op(32'd5, 32'd0, 1'b1, 64'h0, 1'b1, 0, 0, 0, "chain_zero");
    endtask

    task automatic test_operand_change;
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, model(32'h12345678, 32'h9ABCDEF0, 1'b1),
               1'b0, 10, 0, 0, "opchange");
    endtask

    task automatic test_flush;
        run_op(32'd1000, 32'd1000, 1'b0, model(32'd1000, 32'd1000, 1'b0), 1'b0, 0, 15, 0, "flush_run");
        run_op(32'hDEADBEEF, 32'h7, 1'b1, model(32'hDEADBEEF, 32'h7, 1'b1), 1'b0, 0, c_LAT - 1, 0, "flush_fix");
    endtask

    task automatic test_reset_mid;
        run_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0), 1'b0, 0, 0, 20, "reset_run");
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 1'b0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i == 2) a = 32'h80000000;
            if (i == 5) b = 32'h0;
            run_op(a, b, s, model(a, b, s), 1'b0, 0, 0, 0, "random");
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            run_op(a, b, s, model(a, b, s), (i != 0), 0, 0, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_flush_idle();
        test_vectors();
        test_operand_change();
        test_flush();
        test_reset_mid();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
